// File: rtl/sram16_responder_if.sv
// -----------------------------------------------------------------------------
// sram16_responder_if
// Bus-side signal bundle between a CPU-core initiator and the 16-bit SRAM
// responder. The initiator holds cyc_i high until it sees a one-cycle ack_o.
//
//   cyc_i  : bus cycle request
//   we_i   : 1 = write, 0 = read
//   adr_i  : byte address
//   dat_i  : write data
//   sel_i  : byte enables, sel_i[3] = dat[31:24] = lowest byte address
//   dat_o  : read data, valid while ack_o = 1
//   ack_o  : one-cycle transfer-complete pulse
//
// master: initiator view, slave: responder view.
// -----------------------------------------------------------------------------
interface sram16_responder_if;
    logic        cyc_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/sram16_responder.sv
// -----------------------------------------------------------------------------
// sram16_responder
// Serves 32-bit bus transactions from an external asynchronous 16-bit SRAM.
// Each word access becomes up to two halfword accesses (upper half first),
// each strobed for WAIT cycles, with a one-cycle gap between them for write
// recovery / bus turnaround. Halfwords with no enabled byte lanes are skipped.
//
// Parameters
//   AW   : SRAM halfword address width; byte-address bits above AW alias.
//   WAIT : cycles each SRAM strobe is held per halfword (1..15).
//
// Ports
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   bus            : bus responder side (sram16_responder_if.slave)
//   sram_addr      : halfword address to the SRAM
//   sram_dq_o/_i   : data to / from the SRAM pins
//   sram_dq_oe     : tristate enable for sram_dq_o
//   sram_*_n       : active-low SRAM strobes (ce, oe, we, ub, lb)
//
// Every output is a register; bus inputs only reach the pins through flops.
// -----------------------------------------------------------------------------
module sram16_responder #(
    parameter int AW   = 19,
    parameter int WAIT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    sram16_responder_if.slave bus,
    output logic [AW-1:0]     sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_GAP,
        S_ACC1,
        S_ACK
    } state_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(WAIT - 1);

    state_t         r_state;
    logic           r_we;
    logic [AW-2:0]  r_word;
    logic [31:0]    r_dat;
    logic [3:0]     r_sel;
    logic [3:0]     r_wait;
    logic [31:0]    r_rd;
    logic [31:0]    r_dat_o;
    logic           r_ack;
    logic [AW-1:0]  r_addr;
    logic [15:0]    r_dq_o;
    logic           r_dq_oe;
    logic           r_ce_n;
    logic           r_oe_n;
    logic           r_we_n;
    logic           r_ub_n;
    logic           r_lb_n;

    logic           w_last;
    logic [31:0]    w_rd_hi;
    logic [31:0]    w_rd_lo;
    logic           w_unused;

    // Last wait cycle of the current strobe window.
    assign w_last  = (r_wait == LP_WAIT_LAST);

    // Read register as it will look once this cycle's capture lands; writes
    // always return zero.
    assign w_rd_hi = r_we ? 32'h0 : {sram_dq_i, r_rd[15:0]};
    assign w_rd_lo = r_we ? 32'h0 : {r_rd[31:16], sram_dq_i};

    // Address bits outside the word index are don't-care (aliasing).
    assign w_unused = ^{bus.adr_i[31:AW+1], bus.adr_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_word  <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_wait  <= '0;
            r_rd    <= '0;
            r_dat_o <= '0;
            r_ack   <= 1'b0;
            r_addr  <= '0;
            r_dq_o  <= '0;
            r_dq_oe <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cyc_i) begin
                        r_we   <= bus.we_i;
                        r_word <= bus.adr_i[AW:2];
                        r_dat  <= bus.dat_i;
                        r_sel  <= bus.sel_i;
                        r_wait <= '0;
                        if (bus.sel_i[3:2] != 2'b00) begin
                            r_state <= S_ACC0;
                            r_addr  <= {bus.adr_i[AW:2], 1'b0};
                            r_dq_o  <= bus.dat_i[31:16];
                            r_ub_n  <= ~bus.sel_i[3];
                            r_lb_n  <= ~bus.sel_i[2];
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= bus.we_i;
                            r_we_n  <= ~bus.we_i;
                            r_dq_oe <= bus.we_i;
                        end else if (bus.sel_i[1:0] != 2'b00) begin
                            r_state <= S_ACC1;
                            r_addr  <= {bus.adr_i[AW:2], 1'b1};
                            r_dq_o  <= bus.dat_i[15:0];
                            r_ub_n  <= ~bus.sel_i[1];
                            r_lb_n  <= ~bus.sel_i[0];
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= bus.we_i;
                            r_we_n  <= ~bus.we_i;
                            r_dq_oe <= bus.we_i;
                        end else begin
                            // No lanes enabled: acknowledge without touching the SRAM.
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            r_dat_o <= '0;
                        end
                    end
                end

                S_ACC0: begin
                    if (w_last) begin
                        if (!r_we) begin
                            r_rd[31:16] <= sram_dq_i;
                        end
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        if (r_sel[1:0] != 2'b00) begin
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_ACK;
                            r_ack   <= bus.cyc_i;
                            r_dat_o <= w_rd_hi;
                        end
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                S_GAP: begin
                    r_state <= S_ACC1;
                    r_wait  <= '0;
                    r_addr  <= {r_word, 1'b1};
                    r_dq_o  <= r_dat[15:0];
                    r_ub_n  <= ~r_sel[1];
                    r_lb_n  <= ~r_sel[0];
                    r_ce_n  <= 1'b0;
                    r_oe_n  <= r_we;
                    r_we_n  <= ~r_we;
                    r_dq_oe <= r_we;
                end

                S_ACC1: begin
                    if (w_last) begin
                        if (!r_we) begin
                            r_rd[15:0] <= sram_dq_i;
                        end
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_state <= S_ACK;
                        // An abandoned cycle still finishes on the SRAM but is not acked.
                        r_ack   <= bus.cyc_i;
                        r_dat_o <= w_rd_lo;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end

                S_ACK: begin
                    r_state <= S_IDLE;
                    r_rd    <= '0;
                    r_dat_o <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dat_o  = r_dat_o;
    assign bus.ack_o  = r_ack;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_ub_n  = r_ub_n;
    assign sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_sram16_responder.sv
`timescale 1ns/1ps
module tb_sram16_responder;
    localparam int AW   = 19;
    localparam int WAIT = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    sram16_responder_if bus();

    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_o;
    logic [15:0]   sram_dq_i = 16'hA5A5;
    logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram16_responder #(.AW(AW), .WAIT(WAIT)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    typedef struct {
        logic [31:0] dat;
        int          issue;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int cnt    = 0;

    int ce_low_total = 0, we_low_total = 0, we_runs_total = 0;
    int overlap_err = 0, coin_err = 0, stab_err = 0;
    logic          prev_we_n = 1'b1, prev_ce_n = 1'b1;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] last_acc_addr = '0;
    logic          last_ub_n = 1'b1, last_lb_n = 1'b1;

    logic [15:0] mem [0:(1<<AW)-1];

    always @(posedge clk_i) cnt++;

    // Asynchronous SRAM model, evaluated mid-cycle.
    always @(negedge clk_i) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq_o[15:8];
            if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq_o[7:0];
        end
        sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hA5A5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pin-level sanity counters and scoreboard pop on every ack.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (!sram_ce_n) begin
                ce_low_total++;
                last_acc_addr = sram_addr;
                last_ub_n     = sram_ub_n;
                last_lb_n     = sram_lb_n;
                if (!prev_ce_n && sram_addr != prev_addr) stab_err++;
            end
            if (!sram_we_n) begin
                we_low_total++;
                if (prev_we_n) we_runs_total++;
            end
            if (!sram_oe_n && sram_dq_oe) overlap_err++;
            if ((sram_we_n != ~sram_dq_oe) || (!sram_we_n && sram_ce_n)) coin_err++;
            prev_we_n = sram_we_n;
            prev_ce_n = sram_ce_n;
            prev_addr = sram_addr;
            if (bus.ack_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack_o=1 dat_o=%h at cnt %0d, required no ack", bus.dat_o, cnt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_dat"}, bus.dat_o, e.dat);
                    check({e.name, "_cycle"}, 32'(cnt - e.issue), 32'(e.cyc));
                    $display("txn %s: dat_o=%h cycle=%0d (expect %h cycle %0d)",
                             e.name, bus.dat_o, cnt - e.issue, e.dat, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus.cyc_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = adr;
        bus.dat_i = dat;
        bus.sel_i = sel;
    endtask

    task automatic req(input string name, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [31:0] exp_dat, input int exp_cyc);
        int n;
        exp_t e;
        @(negedge clk_i);
        e.dat = exp_dat; e.issue = cnt; e.cyc = exp_cyc; e.name = name;
        sb.push_back(e);
        drive(we, adr, dat, sel);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.ack_o && n < 40);
        bus.cyc_i = 1'b0;
        if (!bus.ack_o) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no ack_o within %0d cycles, required ack", name, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    int ce0, we0, wr0;
    int n;

    initial begin
        bus.cyc_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("reset_outs", {bus.ack_o, sram_dq_oe, 30'h0}, 32'h0);
        check("reset_dat_o", bus.dat_o, 32'h0);
        check("reset_addr", 32'(sram_addr), 32'h0);
        check("reset_dq_o", 32'(sram_dq_o), 32'h0);
        rst_i = 1'b0;

        // Full word write.
        we0 = we_low_total; wr0 = we_runs_total;
        req("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2*WAIT+2);
        check("wr_full_hw8", 32'(mem[8]), 32'hDEAD);
        check("wr_full_hw9", 32'(mem[9]), 32'hBEEF);
        check("wr_full_we_cycles", 32'(we_low_total - we0), 32'd4);
        check("wr_full_we_runs", 32'(we_runs_total - wr0), 32'd2);

        req("rd_full", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 2*WAIT+2);

        // Byte write to the lowest-significance lane only.
        ce0 = ce_low_total;
        req("wr_byte", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, WAIT+1);
        check("wr_byte_ce_cycles", 32'(ce_low_total - ce0), 32'd2);
        check("wr_byte_addr", 32'(last_acc_addr), 32'd9);
        check("wr_byte_lanes", {30'h0, last_ub_n, last_lb_n}, 32'b10);
        check("wr_byte_hw9", 32'(mem[9]), 32'hBEAA);
        req("rd_after_byte", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 2*WAIT+2);

        ce0 = ce_low_total;
        req("rd_hi", 1'b0, 32'h10, 32'h0, 4'b1100, 32'hDEAD0000, WAIT+1);
        check("rd_hi_ce_cycles", 32'(ce_low_total - ce0), 32'd2);
        req("rd_lo", 1'b0, 32'h10, 32'h0, 4'b0011, 32'h0000BEAA, WAIT+1);
        ce0 = ce_low_total;
        req("rd_none", 1'b0, 32'h10, 32'h0, 4'b0000, 32'h0, 1);
        check("rd_none_ce_cycles", 32'(ce_low_total - ce0), 32'd0);
        // Address bit above the SRAM range aliases.
        req("rd_alias", 1'b0, 32'h0010_0010, 32'h0, 4'hF, 32'hDEADBEAA, 2*WAIT+2);

        // Reset during the second halfword of a write.
        @(negedge clk_i);
        drive(1'b1, 32'h20, 32'h11112222, 4'hF);
        n = 0;
        while (!(sram_ce_n == 1'b0 && sram_addr == 19'd17) && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("rst_reach_acc1", 32'(n < 40), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_async_oe", {31'h0, sram_dq_oe}, 32'h0);
        check("rst_async_ack", {31'h0, bus.ack_o}, 32'h0);
        bus.cyc_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_hw16", 32'(mem[16]), 32'h1111);
        req("rd_after_rst", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 2*WAIT+2);

        // Abandoned write: SRAM sequence completes, no ack.
        we0 = we_low_total;
        @(negedge clk_i);
        drive(1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        @(negedge clk_i);
        bus.cyc_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("drop_hw24", 32'(mem[24]), 32'hCAFE);
        check("drop_hw25", 32'(mem[25]), 32'hF00D);
        check("drop_we_cycles", 32'(we_low_total - we0), 32'd4);
        req("rd_after_drop", 1'b0, 32'h30, 32'h0, 4'hF, 32'hCAFEF00D, 2*WAIT+2);

        repeat (4) @(negedge clk_i);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("oe_dq_overlap", 32'(overlap_err), 32'd0);
        check("we_ce_coincide", 32'(coin_err), 32'd0);
        check("addr_stable", 32'(stab_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
